// File: rtl/mem_access_stage.sv
// mem_access_stage: VeSPA MEM stage with EXE/MEM register, data-bus req/ack FSM with timeout
// abort, and MEM/WB register feeding write-back and EXE forwarding.
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Valid,
    input  logic [DATA_W-1:0] i_AluOut,
    input  logic [DATA_W-1:0] i_AluOp2,
    input  logic [DATA_W-1:0] i_Imm22,
    input  logic [DATA_W-1:0] i_ImmOpX,
    input  logic              i_MemRead,
    input  logic              i_MemWrite,
    input  logic              i_AddrSel,
    input  logic [1:0]        i_WbSel,
    input  logic              i_RegWrite,
    input  logic [RD_W-1:0]   i_Rd,
    output logic              o_MemReq,
    output logic              o_MemWe,
    output logic [DATA_W-1:0] o_MemAddr,
    output logic [DATA_W-1:0] o_MemWData,
    input  logic              i_MemAck,
    input  logic [DATA_W-1:0] i_MemRData,
    output logic              o_Stall,
    output logic [DATA_W-1:0] o_AluOutMem,
    output logic [DATA_W-1:0] o_Immed22Mem,
    output logic              o_WbValid,
    output logic              o_WbRegWrite,
    output logic [RD_W-1:0]   o_WbRd,
    output logic [DATA_W-1:0] o_WbData,
    output logic              o_BusErr
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} stateT;

    stateT             state, nextState;
    logic [CW-1:0]     cnt, nextCnt;
    logic              mValid, mMemRead, mMemWrite, mAddrSel, mRegWrite;
    logic [1:0]        mWbSel;
    logic [DATA_W-1:0] mAluOut, mAluOp2, mImm22, mImmOpX;
    logic [RD_W-1:0]   mRd;
    logic              memOp;
    logic [DATA_W-1:0] wbSelData;

    assign memOp        = mValid & (mMemRead | mMemWrite);
    assign o_MemWe      = mMemWrite;
    assign o_MemAddr    = mAddrSel ? mImmOpX : mImm22;
    assign o_MemWData   = mAluOp2;
    assign o_AluOutMem  = mAluOut;
    assign o_Immed22Mem = mImm22;
    assign o_BusErr     = state == ERR;
    assign o_Stall      = memOp & ~(i_MemAck & o_MemReq) & ~o_BusErr;
    // WbSel 11 is reserved and falls through to the ALU result
    assign wbSelData    = mWbSel == 2'b01 ? i_MemRData : mWbSel == 2'b10 ? mImm22 : mAluOut;

    always_comb begin
        o_MemReq  = (state == WAIT) | ((state == IDLE) & memOp);
        nextState = state == IDLE ? ((memOp & ~i_MemAck) ? WAIT : IDLE)
                  : state == WAIT ? (i_MemAck ? IDLE : (cnt == CW'(TIMEOUT - 1)) ? ERR : WAIT)
                  : IDLE;
        nextCnt   = (nextState == WAIT) ? cnt + CW'(1) : '0;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mValid       <= 1'b0;
            mMemRead     <= 1'b0;
            mMemWrite    <= 1'b0;
            mAddrSel     <= 1'b0;
            mRegWrite    <= 1'b0;
            mWbSel       <= '0;
            mAluOut      <= '0;
            mAluOp2      <= '0;
            mImm22       <= '0;
            mImmOpX      <= '0;
            mRd          <= '0;
            o_WbValid    <= 1'b0;
            o_WbRegWrite <= 1'b0;
            o_WbRd       <= '0;
            o_WbData     <= '0;
        end else begin
            state        <= nextState;
            cnt          <= nextCnt;
            // a stall inserts a bubble into WB and freezes M
            o_WbValid    <= ~o_Stall & mValid;
            o_WbRegWrite <= ~o_Stall & mRegWrite & ~o_BusErr;
            if (!o_Stall) begin
                mValid    <= i_Valid;
                mMemRead  <= i_MemRead;
                mMemWrite <= i_MemWrite;
                mAddrSel  <= i_AddrSel;
                mRegWrite <= i_RegWrite;
                mWbSel    <= i_WbSel;
                mAluOut   <= i_AluOut;
                mAluOp2   <= i_AluOp2;
                mImm22    <= i_Imm22;
                mImmOpX   <= i_ImmOpX;
                mRd       <= i_Rd;
                o_WbRd    <= mRd;
                o_WbData  <= wbSelData;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: table vectors, directed multi-cycle sequences, and a randomized run
// scored against an in-order transaction model of the MEM stage.
module tb_mem_access_stage;
    localparam int TIMEOUT = 16;
    localparam int NRAND   = 300;

    logic        i_Clk, i_Rst, i_Valid, i_MemRead, i_MemWrite, i_AddrSel, i_RegWrite, i_MemAck;
    logic [31:0] i_AluOut, i_AluOp2, i_Imm22, i_ImmOpX, i_MemRData;
    logic [1:0]  i_WbSel;
    logic [4:0]  i_Rd;
    logic        o_MemReq, o_MemWe, o_Stall, o_WbValid, o_WbRegWrite, o_BusErr;
    logic [31:0] o_MemAddr, o_MemWData, o_AluOutMem, o_Immed22Mem, o_WbData;
    logic [4:0]  o_WbRd;

    mem_access_stage #(.DATA_W(32), .RD_W(5), .TIMEOUT(TIMEOUT)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Valid(i_Valid), .i_AluOut(i_AluOut),
        .i_AluOp2(i_AluOp2), .i_Imm22(i_Imm22), .i_ImmOpX(i_ImmOpX),
        .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_AddrSel(i_AddrSel),
        .i_WbSel(i_WbSel), .i_RegWrite(i_RegWrite), .i_Rd(i_Rd),
        .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr),
        .o_MemWData(o_MemWData), .i_MemAck(i_MemAck), .i_MemRData(i_MemRData),
        .o_Stall(o_Stall), .o_AluOutMem(o_AluOutMem), .o_Immed22Mem(o_Immed22Mem),
        .o_WbValid(o_WbValid), .o_WbRegWrite(o_WbRegWrite), .o_WbRd(o_WbRd),
        .o_WbData(o_WbData), .o_BusErr(o_BusErr)
    );

    typedef struct {
        logic        valid, memRead, memWrite, addrSel, regWrite;
        logic [1:0]  wbSel;
        logic [31:0] aluOut, aluOp2, imm22, immOpX, rdata;
        logic [4:0]  rd;
        int          lat;
    } instrT;

    typedef struct {
        logic [31:0] aluOut, imm22;
        logic [1:0]  wbSel;
        logic        regWrite;
        logic [4:0]  rd;
        logic [31:0] expData;
        logic        expRegWrite;
    } vecT;

    int checks = 0;
    int failures = 0;

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    function automatic instrT nop();
        instrT x = '{default: 0};
        return x;
    endfunction

    task automatic setExe(input instrT x);
        i_Valid    = x.valid;
        i_AluOut   = x.aluOut;
        i_AluOp2   = x.aluOp2;
        i_Imm22    = x.imm22;
        i_ImmOpX   = x.immOpX;
        i_MemRead  = x.memRead;
        i_MemWrite = x.memWrite;
        i_AddrSel  = x.addrSel;
        i_WbSel    = x.wbSel;
        i_RegWrite = x.regWrite;
        i_Rd       = x.rd;
    endtask

    function automatic logic [31:0] expData(input instrT x);
        return x.wbSel == 2'b01 ? x.rdata : x.wbSel == 2'b10 ? x.imm22 : x.aluOut;
    endfunction

    function automatic instrT randInstr();
        instrT x;
        int k, r;
        k = $urandom_range(0, 3);
        r = $urandom_range(0, 2);
        x.valid    = $urandom_range(0, 4) != 0;
        x.memRead  = (k == 1) || (k == 3);
        x.memWrite = (k == 2) || (k == 3);
        x.addrSel  = 1'($urandom_range(0, 1));
        x.regWrite = 1'($urandom_range(0, 1));
        x.wbSel    = k == 1 ? 2'b01 : r == 0 ? 2'b00 : r == 1 ? 2'b10 : 2'b11;
        x.aluOut   = $urandom;
        x.aluOp2   = $urandom;
        x.imm22    = $urandom;
        x.immOpX   = $urandom;
        x.rdata    = $urandom;
        x.rd       = 5'($urandom_range(0, 31));
        r = $urandom_range(0, 9);
        x.lat      = r < 3 ? 0 : r < 9 ? r - 2 : 99;
        return x;
    endfunction

    vecT vecs[6];
    instrT x, y, cur, mCur, e;
    instrT retQ[$];
    instrT memQ[$];
    int n, reqCycles, issued;
    bit seen, stallPrev, errExp, isErr;

    initial begin
        vecs[0] = '{32'h0000_1234, 32'h0000_0000, 2'b00, 1'b1, 5'd3,  32'h0000_1234, 1'b1};
        vecs[1] = '{32'hAAAA_0000, 32'h00AB_CDEF, 2'b10, 1'b1, 5'd7,  32'h00AB_CDEF, 1'b1};
        vecs[2] = '{32'hCAFE_BABE, 32'h0000_0007, 2'b11, 1'b1, 5'd12, 32'hCAFE_BABE, 1'b1};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 5'd31, 32'hFFFF_FFFF, 1'b0};
        vecs[4] = '{32'h0000_0005, 32'h0000_0000, 2'b10, 1'b1, 5'd0,  32'h0000_0000, 1'b1};
        vecs[5] = '{32'h8000_0001, 32'h003F_FFFF, 2'b00, 1'b1, 5'd17, 32'h8000_0001, 1'b1};

        i_Rst = 1'b0;
        i_MemAck = 1'b0;
        i_MemRData = '0;
        setExe(nop());
        repeat (3) tick();
        @(negedge i_Clk);
        chk("rst.req", o_MemReq, 0);
        chk("rst.we", o_MemWe, 0);
        chk("rst.addr", o_MemAddr, 0);
        chk("rst.stall", o_Stall, 0);
        chk("rst.wbvalid", o_WbValid, 0);
        chk("rst.wbregwrite", o_WbRegWrite, 0);
        chk("rst.wbdata", o_WbData, 0);
        chk("rst.fwd", o_AluOutMem, 0);
        chk("rst.buserr", o_BusErr, 0);
        i_Rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            x = nop();
            x.valid = 1'b1;
            x.aluOut = vecs[i].aluOut;
            x.imm22 = vecs[i].imm22;
            x.wbSel = vecs[i].wbSel;
            x.regWrite = vecs[i].regWrite;
            x.rd = vecs[i].rd;
            setExe(x);
            tick();
            setExe(nop());
            @(negedge i_Clk);
            chk($sformatf("vec%0d.req", i), o_MemReq, 0);
            chk($sformatf("vec%0d.fwd", i), o_AluOutMem, vecs[i].aluOut);
            tick();
            @(negedge i_Clk);
            chk($sformatf("vec%0d.wbvalid", i), o_WbValid, 1);
            chk($sformatf("vec%0d.wbdata", i), o_WbData, vecs[i].expData);
            chk($sformatf("vec%0d.wbrd", i), o_WbRd, vecs[i].rd);
            chk($sformatf("vec%0d.wbregwrite", i), o_WbRegWrite, vecs[i].expRegWrite);
        end
        tick();

        // zero-wait load
        x = nop();
        x.valid = 1'b1; x.memRead = 1'b1; x.wbSel = 2'b01; x.imm22 = 32'h40; x.regWrite = 1'b1; x.rd = 5'd4;
        setExe(x);
        tick();
        setExe(nop());
        i_MemAck = 1'b1;
        i_MemRData = 32'hDEAD;
        @(negedge i_Clk);
        chk("ld0.req", o_MemReq, 1);
        chk("ld0.we", o_MemWe, 0);
        chk("ld0.addr", o_MemAddr, 32'h40);
        chk("ld0.stall", o_Stall, 0);
        tick();
        i_MemAck = 1'b0;
        @(negedge i_Clk);
        chk("ld0.wbvalid", o_WbValid, 1);
        chk("ld0.wbdata", o_WbData, 32'hDEAD);
        chk("ld0.wbrd", o_WbRd, 4);
        chk("ld0.req_after", o_MemReq, 0);
        tick();

        // STX acknowledged three cycles after the request
        x = nop();
        x.valid = 1'b1; x.memWrite = 1'b1; x.addrSel = 1'b1; x.immOpX = 32'h80; x.imm22 = 32'h123;
        x.aluOp2 = 32'h55; x.rd = 5'd9;
        setExe(x);
        tick();
        setExe(nop());
        for (int k = 0; k < 3; k++) begin
            @(negedge i_Clk);
            chk($sformatf("stx.stall%0d", k), o_Stall, 1);
            chk($sformatf("stx.req%0d", k), o_MemReq, 1);
            chk($sformatf("stx.we%0d", k), o_MemWe, 1);
            chk($sformatf("stx.addr%0d", k), o_MemAddr, 32'h80);
            chk($sformatf("stx.wdata%0d", k), o_MemWData, 32'h55);
            tick();
        end
        i_MemAck = 1'b1;
        @(negedge i_Clk);
        chk("stx.stall_ack", o_Stall, 0);
        tick();
        i_MemAck = 1'b0;
        @(negedge i_Clk);
        chk("stx.wbvalid", o_WbValid, 1);
        chk("stx.wbregwrite", o_WbRegWrite, 0);
        tick();

        // load that is never acknowledged
        x = nop();
        x.valid = 1'b1; x.memRead = 1'b1; x.wbSel = 2'b01; x.imm22 = 32'h90; x.regWrite = 1'b1; x.rd = 5'd6;
        setExe(x);
        tick();
        setExe(nop());
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_Clk);
            if (o_BusErr) begin
                seen = 1'b1;
                break;
            end
            if (o_MemReq) n++;
            tick();
        end
        chk("to.seen", seen, 1);
        chk("to.reqcycles", n, TIMEOUT);
        chk("to.req_err", o_MemReq, 0);
        chk("to.stall_err", o_Stall, 0);
        tick();
        @(negedge i_Clk);
        chk("to.wbvalid", o_WbValid, 1);
        chk("to.wbregwrite", o_WbRegWrite, 0);
        chk("to.buserr_end", o_BusErr, 0);
        tick();

        // reset while waiting, then LDI
        setExe(x);
        tick();
        setExe(nop());
        repeat (2) tick();
        @(negedge i_Clk);
        chk("rw.req_before", o_MemReq, 1);
        i_Rst = 1'b0;
        tick();
        i_Rst = 1'b1;
        @(negedge i_Clk);
        chk("rw.req", o_MemReq, 0);
        chk("rw.stall", o_Stall, 0);
        chk("rw.addr", o_MemAddr, 0);
        chk("rw.fwd", o_Immed22Mem, 0);
        chk("rw.wbvalid", o_WbValid, 0);
        x = nop();
        x.valid = 1'b1; x.wbSel = 2'b10; x.imm22 = 32'h3F_FFFF; x.regWrite = 1'b1; x.rd = 5'd9;
        setExe(x);
        tick();
        setExe(nop());
        tick();
        @(negedge i_Clk);
        chk("rw.ldi_valid", o_WbValid, 1);
        chk("rw.ldi_data", o_WbData, 32'h3F_FFFF);
        chk("rw.ldi_regwrite", o_WbRegWrite, 1);
        tick();

        // load followed by a dependent ALU op held in EXE during the stall
        x = nop();
        x.valid = 1'b1; x.memRead = 1'b1; x.wbSel = 2'b01; x.imm22 = 32'h44; x.aluOut = 32'h1111;
        x.regWrite = 1'b1; x.rd = 5'd2;
        y = nop();
        y.valid = 1'b1; y.aluOut = 32'h777; y.imm22 = 32'h5; y.regWrite = 1'b1; y.rd = 5'd8;
        setExe(x);
        tick();
        setExe(y);
        for (int k = 0; k < 2; k++) begin
            @(negedge i_Clk);
            chk($sformatf("dep.stall%0d", k), o_Stall, 1);
            chk($sformatf("dep.fwdalu%0d", k), o_AluOutMem, 32'h1111);
            chk($sformatf("dep.fwdimm%0d", k), o_Immed22Mem, 32'h44);
            tick();
        end
        i_MemAck = 1'b1;
        i_MemRData = 32'hBEEF;
        tick();
        setExe(nop());
        i_MemAck = 1'b0;
        @(negedge i_Clk);
        chk("dep.lddata", o_WbData, 32'hBEEF);
        chk("dep.fwdalu_next", o_AluOutMem, 32'h777);
        tick();
        @(negedge i_Clk);
        chk("dep.aluvalid", o_WbValid, 1);
        chk("dep.aludata", o_WbData, 32'h777);
        chk("dep.alurd", o_WbRd, 8);

        // randomized traffic against the in-order model
        cur = nop();
        setExe(cur);
        repeat (2) tick();
        mCur = cur;
        reqCycles = 0;
        issued = 0;
        errExp = 1'b0;
        @(negedge i_Clk);
        stallPrev = o_Stall;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            tick();
            if (!stallPrev) begin
                mCur = cur;
                if (cur.valid) retQ.push_back(cur);
                if (cur.valid && (cur.memRead || cur.memWrite)) memQ.push_back(cur);
                cur = issued < NRAND ? randInstr() : nop();
                issued++;
                setExe(cur);
            end
            if (o_MemReq && memQ.size() > 0) begin
                i_MemAck = reqCycles == memQ[0].lat;
                i_MemRData = memQ[0].rdata;
            end else begin
                i_MemAck = 1'($urandom_range(0, 1));
                i_MemRData = $urandom;
            end
            @(negedge i_Clk);
            chk("rnd.fwdalu", o_AluOutMem, mCur.aluOut);
            chk("rnd.fwdimm", o_Immed22Mem, mCur.imm22);
            chk("rnd.stall", o_Stall, o_MemReq && !i_MemAck);
            chk("rnd.buserr", o_BusErr, errExp);
            errExp = 1'b0;
            if (o_MemReq) begin
                chk("rnd.req_pending", memQ.size() > 0, 1);
                if (memQ.size() > 0) begin
                    chk("rnd.addr", o_MemAddr, memQ[0].addrSel ? memQ[0].immOpX : memQ[0].imm22);
                    chk("rnd.we", o_MemWe, memQ[0].memWrite);
                    chk("rnd.wdata", o_MemWData, memQ[0].aluOp2);
                    if (i_MemAck) begin
                        void'(memQ.pop_front());
                        reqCycles = 0;
                    end else begin
                        reqCycles++;
                        if (reqCycles == TIMEOUT) begin
                            void'(memQ.pop_front());
                            reqCycles = 0;
                            errExp = 1'b1;
                        end
                    end
                end
            end
            if (o_WbValid) begin
                chk("rnd.ret_pending", retQ.size() > 0, 1);
                if (retQ.size() > 0) begin
                    e = retQ.pop_front();
                    isErr = (e.memRead || e.memWrite) && e.lat >= TIMEOUT;
                    chk("rnd.wbrd", o_WbRd, e.rd);
                    chk("rnd.wbregwrite", o_WbRegWrite, e.regWrite && !isErr);
                    if (!isErr) chk("rnd.wbdata", o_WbData, expData(e));
                end
            end
            stallPrev = o_Stall;
            if (issued > NRAND && retQ.size() == 0 && memQ.size() == 0 && !stallPrev) break;
        end
        chk("rnd.drain_ret", retQ.size(), 0);
        chk("rnd.drain_mem", memQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
